alu_decode: RTL and testbench
=============================

# alu_decode

Registered decode/issue stage that sits directly in front of `alu`. It accepts one RV32I instruction per cycle with its PC and register-file read data, and generates the ALU `op[3:0]`, the operands `a`/`b`, the control-transfer target and the branch-sense bit. All outputs are held in a single valid/ready pipeline register. Downstream logic computes `taken = z ^ out_br_inv` from the ALU `z` output.

## Interface
- `RESET_PC`, default 32'h0000_0000: reset value of `out_pc`.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of the stage contents.
- `in_valid` in 1: upstream holds a valid instruction.
- `in_ready` out 1: the stage accepts the instruction this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in 32: instruction PC.
- `in_rs1` in 32: register-file data for rs1.
- `in_rs2` in 32: register-file data for rs2.
- `out_valid` out 1: payload valid.
- `out_ready` in 1: downstream consumes the payload.
- `out_op` out 4: ALU op.
- `out_a` out 32: ALU operand a.
- `out_b` out 32: ALU operand b.
- `out_cls` out 3: class. 0 ALU, 1 BRANCH, 2 LOAD, 3 STORE, 4 JAL, 5 JALR, 7 ILLEGAL.
- `out_br_inv` out 1: invert `z` to get the branch-taken result.
- `out_tgt` out 32: branch/jump target, or the store data for STORE.
- `out_rd` out 5: destination register, 0 for BRANCH/STORE.
- `out_pc` out 32: registered PC.

## Operation
- Immediates are decoded per the RV32I I/S/B/U/J formats and sign-extended to 32 bits.
- OP (0110011):
  - op = {f7[5], f3}, a = rs1, b = rs2.
  - f7 must be 0000000, or 0100000 only with f3 of 000 or 101. Any other f7 is ILLEGAL.
- OP-IMM (0010011):
  - op[2:0] = f3, a = rs1, b = I-imm.
  - op[3] = f7[5] only when f3 = 101. Otherwise op[3] = 0.
  - For f3 of 001 or 101, f7 must be 0000000, or 0100000 only with f3 = 101. Any other f7 is ILLEGAL.
- LUI: op 0000, a = 0, b = U-imm.
- AUIPC: op 0000, a = pc, b = U-imm.
- JAL: op 0000, a = pc, b = 4, tgt = pc + J-imm.
- JALR: op 0000, a = pc, b = 4, tgt = (rs1 + I-imm) & ~1.
- BRANCH (1100011):
  - a = rs1, b = rs2, tgt = pc + B-imm.
  - BEQ and BNE use op 1000 (SUB); BLT and BGE use op 0010 (SLT); BLTU and BGEU use op 0011 (SLTU).
  - br_inv = 1 for BNE, BLT and BLTU; 0 otherwise.
  - f3 of 010 or 011 is ILLEGAL.
- LOAD: op 0000, a = rs1, b = I-imm.
- STORE: op 0000, a = rs1, b = S-imm, tgt = rs2.
- ILLEGAL: any other opcode, or `instr[1:0]` not equal to 11. The payload is cls 7, op 0, a = b = tgt = 0, rd 0. The instruction is still forwarded so the trap logic sees it.
- All address and sum arithmetic is 32-bit modulo 2^32; wrap-around is silent.

## Timing
- Reset values:
  - `out_valid` = 0.
  - `out_pc` = RESET_PC.
  - All other outputs = 0.
  - `in_ready` = 1 during and after reset.
- `in_ready = !out_valid || out_ready` (combinational, no bubble). Throughput is 1 instruction/cycle.
- Latency: an instruction accepted at edge N appears with `out_valid` = 1 after edge N.
- While `out_valid && !out_ready`, all `out_*` signals are held stable.
- Load condition: `in_valid && in_ready && !flush` loads the register and sets `out_valid`.
- If `out_ready` is high and nothing is loaded, `out_valid` clears.
- `flush` has priority over everything:
  - The next cycle has `out_valid` = 0.
  - An instruction offered in the flush cycle is dropped, even though `in_ready` may be high.
- An `rst_n` assertion mid-transfer clears `out_valid` immediately, without waiting for a clock edge. The payload is discarded.

## Test plan
- ADD then SUB: `0x002080B3` then `0x402080B3`, rs1 = 5, rs2 = 3, `out_ready` = 1. Expect back-to-back `out_valid`, op 0000 then 1000, a = 5, b = 3, rd 1, cls 0.
- BNE taken: `0x00209463` at pc 0x100. Expect op 1000, br_inv 1, tgt 0x108, cls 1, rd 0.
- Immediates: SRAI `0x4030D093` gives op 1101, b = 3. LUI `0x123450B7` gives a = 0, b = 0x12345000. JALR with rs1 = 0x201 and imm 0 gives tgt 0x200.
- Backpressure: hold `out_ready` = 0 for 3 cycles with `out_valid` = 1. Expect the payload stable and `in_ready` = 0, then transfer and acceptance in the same cycle once `out_ready` rises.
- Illegal: `0x00000000`, then a BRANCH with f3 = 010, then OP with f7 = 0100000 and f3 = 001. Each gives cls 7 with a zeroed payload.
- Flush and reset: assert `flush` together with `in_valid`. Expect `out_valid` = 0 next cycle and the instruction lost. Drop `rst_n` mid-stall. Expect `out_valid` = 0 asynchronously and `out_pc` = RESET_PC.

Source files
------------

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decode
//  Purpose  : RV32I decode/issue stage in front of the ALU. Decodes one
//             instruction per cycle into ALU op, operands, control-transfer
//             target, branch-sense bit and instruction class. The result is
//             held in a single valid/ready pipeline register.
//  Ports    : clk, rst_n (async, active low), flush (sync kill)
//             in_valid/in_ready  : upstream handshake
//             in_instr/in_pc/in_rs1/in_rs2 : instruction, PC, register data
//             out_valid/out_ready: downstream handshake
//             out_op/out_a/out_b : ALU op and operands
//             out_cls            : 0 ALU 1 BRANCH 2 LOAD 3 STORE 4 JAL
//                                  5 JALR 7 ILLEGAL
//             out_br_inv         : taken = z ^ out_br_inv
//             out_tgt            : branch/jump target, store data for STORE
//             out_rd/out_pc      : destination register, registered PC
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_cls,
    output logic        out_br_inv,
    output logic [31:0] out_tgt,
    output logic [4:0]  out_rd,
    output logic [31:0] out_pc
);

    // ------------------------------------------------------------------------
    // Opcodes and class codes
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;

    localparam logic [2:0] c_CLS_ALU     = 3'd0;
    localparam logic [2:0] c_CLS_BRANCH  = 3'd1;
    localparam logic [2:0] c_CLS_LOAD    = 3'd2;
    localparam logic [2:0] c_CLS_STORE   = 3'd3;
    localparam logic [2:0] c_CLS_JAL     = 3'd4;
    localparam logic [2:0] c_CLS_JALR    = 3'd5;
    localparam logic [2:0] c_CLS_ILLEGAL = 3'd7;

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;

    localparam logic [31:0] c_LINK_OFS = 32'd4;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [4:0] w_rd_field;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    assign w_opcode   = in_instr[6:0];
    assign w_rd_field = in_instr[11:7];
    assign w_f3       = in_instr[14:12];
    assign w_f7       = in_instr[31:25];

    // ------------------------------------------------------------------------
    // Sign-extended immediates
    // ------------------------------------------------------------------------
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_shamt;

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'h000};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
    // Immediate shifts carry their funct7 in imm[11:5]; only the shift
    // amount is meaningful as operand b.
    assign w_shamt = {27'd0, in_instr[24:20]};

    // ------------------------------------------------------------------------
    // Target arithmetic (modulo 2^32)
    // ------------------------------------------------------------------------
    logic [31:0] w_br_tgt;
    logic [31:0] w_jal_tgt;
    logic [31:0] w_jalr_sum;
    logic [31:0] w_jalr_tgt;

    assign w_br_tgt   = in_pc + w_imm_b;
    assign w_jal_tgt  = in_pc + w_imm_j;
    assign w_jalr_sum = in_rs1 + w_imm_i;
    assign w_jalr_tgt = {w_jalr_sum[31:1], 1'b0};

    // ------------------------------------------------------------------------
    // Legality checks
    // ------------------------------------------------------------------------
    logic w_f7_zero;
    logic w_f7_alt;
    logic w_op_legal;
    logic w_imm_is_shift;
    logic w_opimm_legal;
    logic w_br_legal;

    assign w_f7_zero      = (w_f7 == 7'b0000000);
    assign w_f7_alt       = (w_f7 == 7'b0100000);
    // Only ADD/SUB and SRL/SRA have an alternate-f7 encoding.
    assign w_op_legal     = w_f7_zero ||
                            (w_f7_alt && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
    assign w_imm_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    // Non-shift OP-IMM uses bits 31:25 as immediate, so f7 is unconstrained.
    assign w_opimm_legal  = !w_imm_is_shift || w_f7_zero ||
                            (w_f7_alt && (w_f3 == 3'b101));
    assign w_br_legal     = (w_f3[2:1] != 2'b01);

    // ------------------------------------------------------------------------
    // Branch compare selection. BEQ/BNE subtract and test zero; the ordered
    // compares produce z = 1 when "not less", so BLT/BLTU invert.
    // ------------------------------------------------------------------------
    logic [3:0] w_br_op;
    logic       w_br_inv_raw;

    always_comb begin
        w_br_op = c_ALU_SUB;
        case (w_f3[2:1])
            2'b10:   w_br_op = c_ALU_SLT;
            2'b11:   w_br_op = c_ALU_SLTU;
            default: w_br_op = c_ALU_SUB;
        endcase
    end

    assign w_br_inv_raw = w_f3[2] ? ~w_f3[0] : w_f3[0];

    // ------------------------------------------------------------------------
    // Payload decode. Defaults describe the ILLEGAL payload; every legal
    // encoding overwrites all fields.
    // ------------------------------------------------------------------------
    logic [3:0]  w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [2:0]  w_cls;
    logic        w_br_inv;
    logic [31:0] w_tgt;
    logic [4:0]  w_rd;

    always_comb begin
        w_op     = 4'd0;
        w_a      = 32'd0;
        w_b      = 32'd0;
        w_cls    = c_CLS_ILLEGAL;
        w_br_inv = 1'b0;
        w_tgt    = 32'd0;
        w_rd     = 5'd0;
        if (in_instr[1:0] == 2'b11) begin
            case (w_opcode)
                c_OPC_OP: begin
                    if (w_op_legal) begin
                        w_op  = {w_f7[5], w_f3};
                        w_a   = in_rs1;
                        w_b   = in_rs2;
                        w_cls = c_CLS_ALU;
                        w_rd  = w_rd_field;
                    end
                end
                c_OPC_OPIMM: begin
                    if (w_opimm_legal) begin
                        w_op  = {(w_f3 == 3'b101) & w_f7[5], w_f3};
                        w_a   = in_rs1;
                        w_b   = w_imm_is_shift ? w_shamt : w_imm_i;
                        w_cls = c_CLS_ALU;
                        w_rd  = w_rd_field;
                    end
                end
                c_OPC_LUI: begin
                    w_op  = c_ALU_ADD;
                    w_a   = 32'd0;
                    w_b   = w_imm_u;
                    w_cls = c_CLS_ALU;
                    w_rd  = w_rd_field;
                end
                c_OPC_AUIPC: begin
                    w_op  = c_ALU_ADD;
                    w_a   = in_pc;
                    w_b   = w_imm_u;
                    w_cls = c_CLS_ALU;
                    w_rd  = w_rd_field;
                end
                c_OPC_JAL: begin
                    // ALU computes the link address pc + 4.
                    w_op  = c_ALU_ADD;
                    w_a   = in_pc;
                    w_b   = c_LINK_OFS;
                    w_cls = c_CLS_JAL;
                    w_tgt = w_jal_tgt;
                    w_rd  = w_rd_field;
                end
                c_OPC_JALR: begin
                    w_op  = c_ALU_ADD;
                    w_a   = in_pc;
                    w_b   = c_LINK_OFS;
                    w_cls = c_CLS_JALR;
                    w_tgt = w_jalr_tgt;
                    w_rd  = w_rd_field;
                end
                c_OPC_BRANCH: begin
                    if (w_br_legal) begin
                        w_op     = w_br_op;
                        w_a      = in_rs1;
                        w_b      = in_rs2;
                        w_cls    = c_CLS_BRANCH;
                        w_br_inv = w_br_inv_raw;
                        w_tgt    = w_br_tgt;
                    end
                end
                c_OPC_LOAD: begin
                    w_op  = c_ALU_ADD;
                    w_a   = in_rs1;
                    w_b   = w_imm_i;
                    w_cls = c_CLS_LOAD;
                    w_rd  = w_rd_field;
                end
                c_OPC_STORE: begin
                    // Store data rides in the target field.
                    w_op  = c_ALU_ADD;
                    w_a   = in_rs1;
                    w_b   = w_imm_s;
                    w_cls = c_CLS_STORE;
                    w_tgt = in_rs2;
                end
                default: begin
                    w_cls = c_CLS_ILLEGAL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Valid/ready pipeline register
    // ------------------------------------------------------------------------
    logic        r_valid;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_cls;
    logic        r_br_inv;
    logic [31:0] r_tgt;
    logic [4:0]  r_rd;
    logic [31:0] r_pc;
    logic        w_load;

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only changes on a load, which keeps it stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_cls    <= 3'd0;
            r_br_inv <= 1'b0;
            r_tgt    <= 32'd0;
            r_rd     <= 5'd0;
            r_pc     <= RESET_PC;
        end else if (w_load) begin
            r_op     <= w_op;
            r_a      <= w_a;
            r_b      <= w_b;
            r_cls    <= w_cls;
            r_br_inv <= w_br_inv;
            r_tgt    <= w_tgt;
            r_rd     <= w_rd;
            r_pc     <= in_pc;
        end
    end

    assign out_valid  = r_valid;
    assign out_op     = r_op;
    assign out_a      = r_a;
    assign out_b      = r_b;
    assign out_cls    = r_cls;
    assign out_br_inv = r_br_inv;
    assign out_tgt    = r_tgt;
    assign out_rd     = r_rd;
    assign out_pc     = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_decode
//  Purpose  : Self-checking bench for alu_decode: directed scenarios plus a
//             randomized run against a mnemonic-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_decode;

    localparam logic [31:0] c_RST_PC = 32'h8000_0004;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cls;
        logic        br_inv;
        logic [31:0] tgt;
        logic [4:0]  rd;
    } pl_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_cls;
    logic        out_br_inv;
    logic [31:0] out_tgt;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;

    pl_t got;
    assign got = {out_op, out_a, out_b, out_cls, out_br_inv, out_tgt, out_rd};

    int n_cmp;
    int n_fail;

    alu_decode #(.RESET_PC(c_RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_cls(out_cls),
        .out_br_inv(out_br_inv), .out_tgt(out_tgt), .out_rd(out_rd),
        .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Helpers (no comparisons inside)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_instr = ins;
        in_pc    = pc;
        in_rs1   = r1;
        in_rs2   = r2;
    endtask

    function automatic pl_t mk(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] cls,
                               input logic inv, input logic [31:0] tgt,
                               input logic [4:0] rd);
        pl_t p;
        p.op = op; p.a = a; p.b = b; p.cls = cls;
        p.br_inv = inv; p.tgt = tgt; p.rd = rd;
        return p;
    endfunction

    // Reference model: decodes by mnemonic with plain integer arithmetic.
    function automatic pl_t model(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] rs1, input logic [31:0] rs2);
        pl_t         p;
        int unsigned opc, rd, f3, f7;
        logic [31:0] ii, is, ib, iu, ij;
        int          v;
        int unsigned br_op [8];
        bit          br_inv [8];
        br_op  = '{8, 8, 0, 0, 2, 2, 3, 3};
        br_inv = '{0, 1, 0, 0, 1, 0, 1, 0};
        p   = mk(4'd0, 32'd0, 32'd0, 3'd7, 1'b0, 32'd0, 5'd0);
        opc = ins & 32'h7F;
        rd  = (ins >> 7) & 31;
        f3  = (ins >> 12) & 7;
        f7  = ins >> 25;
        ii  = $signed(ins) >>> 20;
        is  = (ii & ~32'h1F) | 32'(rd);
        v   = (ins[31] ? -4096 : 0) + int'((ins >> 7) & 1) * 2048 +
              int'((ins >> 25) & 63) * 32 + int'((ins >> 8) & 15) * 2;
        ib  = 32'(v);
        iu  = ins & 32'hFFFF_F000;
        v   = (ins[31] ? -(1 << 20) : 0) + int'((ins >> 12) & 255) * 4096 +
              int'((ins >> 20) & 1) * 2048 + int'((ins >> 21) & 1023) * 2;
        ij  = 32'(v);
        if ((ins & 3) != 3) return p;
        case (opc)
            32'h33: if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))
                p = mk(4'((f7 >> 5) * 8 + f3), rs1, rs2, 3'd0, 1'b0, 32'd0, 5'(rd));
            32'h13: begin
                if (f3 != 1 && f3 != 5)
                    p = mk(4'(f3), rs1, ii, 3'd0, 1'b0, 32'd0, 5'(rd));
                else if (f7 == 0 || (f7 == 32 && f3 == 5))
                    p = mk(4'((f7 >> 5) * 8 + f3), rs1, (ins >> 20) & 31,
                           3'd0, 1'b0, 32'd0, 5'(rd));
            end
            32'h37: p = mk(4'd0, 32'd0, iu, 3'd0, 1'b0, 32'd0, 5'(rd));
            32'h17: p = mk(4'd0, pc, iu, 3'd0, 1'b0, 32'd0, 5'(rd));
            32'h6F: p = mk(4'd0, pc, 32'd4, 3'd4, 1'b0, pc + ij, 5'(rd));
            32'h67: p = mk(4'd0, pc, 32'd4, 3'd5, 1'b0, (rs1 + ii) & ~32'd1, 5'(rd));
            32'h63: if (f3 != 2 && f3 != 3)
                p = mk(4'(br_op[f3]), rs1, rs2, 3'd1, br_inv[f3], pc + ib, 5'd0);
            32'h03: p = mk(4'd0, rs1, ii, 3'd2, 1'b0, 32'd0, 5'(rd));
            32'h23: p = mk(4'd0, rs1, is, 3'd3, 1'b0, rs2, 5'd0);
            default: ;
        endcase
        return p;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: r[6:0] = 7'h33;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h37;
            3: r[6:0] = 7'h17;
            4: r[6:0] = 7'h6F;
            5: r[6:0] = 7'h67;
            6: r[6:0] = 7'h63;
            7: r[6:0] = 7'h03;
            8: r[6:0] = 7'h23;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b required 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_cmp++; if (got !== '0) begin n_fail++;
            $display("FAIL reset_payload: got %h required 0", got); end
        n_cmp++; if (out_pc !== c_RST_PC) begin n_fail++;
            $display("FAIL reset_pc: got %h required %h", out_pc, c_RST_PC); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_sub();
        pl_t e;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(32'h002080B3, 32'h40, 32'd5, 32'd3);
        step();
        e = mk(4'b0000, 32'd5, 32'd3, 3'd0, 1'b0, 32'd0, 5'd1);
        n_cmp++; if (out_valid !== 1'b1 || got !== e || out_pc !== 32'h40) begin n_fail++;
            $display("FAIL add: got v=%b %h pc=%h required v=1 %h pc=40", out_valid, got, out_pc, e); end
        drive(32'h402080B3, 32'h44, 32'd5, 32'd3);
        step();
        e = mk(4'b1000, 32'd5, 32'd3, 3'd0, 1'b0, 32'd0, 5'd1);
        n_cmp++; if (out_valid !== 1'b1 || got !== e || out_pc !== 32'h44) begin n_fail++;
            $display("FAIL sub: got v=%b %h pc=%h required v=1 %h pc=44", out_valid, got, out_pc, e); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL drain: got %b required 0", out_valid); end
    endtask

    task automatic test_bne();
        pl_t e;
        in_valid = 1'b1;
        drive(32'h00209463, 32'h100, 32'd1, 32'd2);
        step();
        e = mk(4'b1000, 32'd1, 32'd2, 3'd1, 1'b1, 32'h108, 5'd0);
        n_cmp++; if (out_valid !== 1'b1 || got !== e) begin n_fail++;
            $display("FAIL bne: got v=%b %h required v=1 %h", out_valid, got, e); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_imm();
        pl_t e;
        in_valid = 1'b1;
        drive(32'h4030D093, 32'h200, 32'hF0, 32'd9);
        step();
        e = mk(4'b1101, 32'hF0, 32'd3, 3'd0, 1'b0, 32'd0, 5'd1);
        n_cmp++; if (got !== e) begin n_fail++;
            $display("FAIL srai: got %h required %h", got, e); end
        drive(32'h123450B7, 32'h204, 32'h77, 32'd9);
        step();
        e = mk(4'b0000, 32'd0, 32'h12345000, 3'd0, 1'b0, 32'd0, 5'd1);
        n_cmp++; if (got !== e) begin n_fail++;
            $display("FAIL lui: got %h required %h", got, e); end
        drive(32'h000080E7, 32'h300, 32'h201, 32'd9);
        step();
        e = mk(4'b0000, 32'h300, 32'd4, 3'd5, 1'b0, 32'h200, 5'd1);
        n_cmp++; if (got !== e || out_pc !== 32'h300) begin n_fail++;
            $display("FAIL jalr: got %h pc=%h required %h pc=300", got, out_pc, e); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        pl_t ea, eb;
        ea = mk(4'd0, 32'h10, 32'd5, 3'd0, 1'b0, 32'd0, 5'd1);
        eb = mk(4'd0, 32'h1000, 32'd4, 3'd3, 1'b0, 32'hDEAD, 5'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(32'h00508093, 32'h500, 32'h10, 32'd0);
        step();
        drive(32'h0020A223, 32'h504, 32'h1000, 32'hDEAD);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== ea || out_pc !== 32'h500) begin n_fail++;
                $display("FAIL stall_%0d: got rdy=%b v=%b %h pc=%h required rdy=0 v=1 %h pc=500",
                         i, in_ready, out_valid, got, out_pc, ea); end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL release_ready: got %b required 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || got !== eb || out_pc !== 32'h504) begin n_fail++;
            $display("FAIL store_after_stall: got v=%b %h pc=%h required v=1 %h pc=504", out_valid, got, out_pc, eb); end
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL bp_drain: got %b required 0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [3];
        pl_t         e;
        ins = '{32'h00000000, 32'h0020A063, 32'h402090B3};
        e   = mk(4'd0, 32'd0, 32'd0, 3'd7, 1'b0, 32'd0, 5'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 32'h600 + 32'(4 * i), 32'h1234, 32'h5678);
            step();
            n_cmp++; if (out_valid !== 1'b1 || got !== e || out_pc !== 32'h600 + 32'(4 * i)) begin n_fail++;
                $display("FAIL illegal_%0d: got v=%b %h pc=%h required v=1 %h", i, out_valid, got, out_pc, e); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(32'h00508093, 32'h700, 32'h1, 32'h2);
        step();
        out_ready = 1'b1;
        flush     = 1'b1;
        drive(32'h00108093, 32'h704, 32'h3, 32'h4);
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_kill: got %b required 0", out_valid); end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_drop: got %b required 0", out_valid); end
    endtask

    task automatic test_random();
        bit          m_valid;
        pl_t         m_pl;
        logic [31:0] m_pc;
        bit          exp_rdy;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        step();
        m_valid = 1'b0;
        m_pl    = '0;
        m_pc    = '0;
        for (int c = 0; c < 1500; c++) begin
            n_cmp++; if (out_valid !== m_valid || (m_valid && (got !== m_pl || out_pc !== m_pc))) begin n_fail++;
                $display("FAIL rand_out_%0d: got v=%b %h pc=%h required v=%b %h pc=%h",
                         c, out_valid, got, out_pc, m_valid, m_pl, m_pc); end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 15) == 0);
            drive(rand_instr(), $urandom, $urandom, $urandom);
            #1;
            exp_rdy = !m_valid || out_ready;
            n_cmp++; if (in_ready !== exp_rdy) begin n_fail++;
                $display("FAIL rand_rdy_%0d: got %b required %b", c, in_ready, exp_rdy); end
            if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && exp_rdy) begin
                m_valid = 1'b1;
                m_pl    = model(in_instr, in_pc, in_rs1, in_rs2);
                m_pc    = in_pc;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(32'h00508093, 32'h900, 32'h1, 32'h2);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL pre_reset_valid: got %b required 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_pc !== c_RST_PC || got !== '0) begin n_fail++;
            $display("FAIL async_reset: got v=%b pc=%h %h required v=0 pc=%h 0", out_valid, out_pc, got, c_RST_PC); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL async_reset_rdy: got %b required 1", in_ready); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_add_sub();
        test_bne();
        test_imm();
        test_backpressure();
        test_illegal();
        test_flush();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
